// File: rtl/i2c_spi_pkg.sv
// Shared types and constants for the I2C-to-SPI bridge receive path.
package i2c_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_e;

  localparam logic [6:0] I2C_ADDR_DEFAULT = 7'h42;

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchroniser plus history flop for one I2C line; flags rising and falling edges.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = line_i;
    hist_d    = sync_q[SYNC_STAGES-1];
  end

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: receives bytes addressed to I2C_ADDR and hands them
// to the SPI stage through a single holding register with valid/ready.
module i2c_target_rx
  import i2c_spi_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = I2C_ADDR_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i2c_wb_clk_i,
  input  logic       i2c_wb_rst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_first_o,
  output logic       busy_o,
  output logic       overrun_o
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i  (i2c_wb_clk_i),
    .rst_i  (i2c_wb_rst_i),
    .line_i (scl_i),
    .level_o(scl),
    .rise_o (scl_rise),
    .fall_o (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i  (i2c_wb_clk_i),
    .rst_i  (i2c_wb_rst_i),
    .line_i (sda_i),
    .level_o(sda),
    .rise_o (sda_rise),
    .fall_o (sda_fall)
  );

  i2c_state_e state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       first_pending_q, first_pending_d;
  logic       busy_q, busy_d;
  logic       overrun_q, overrun_d;

  logic       start_det, stop_det;
  logic [7:0] byte_w;

  assign start_det = sda_fall & scl;
  assign stop_det  = sda_rise & scl;
  assign byte_w    = {shift_q, sda};

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    shift_d         = shift_q;
    sda_oe_d        = sda_oe_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = rx_valid_q;
    rx_first_d      = rx_first_q;
    first_pending_d = first_pending_q;
    busy_d          = busy_q;
    overrun_d       = overrun_q;

    if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 3'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = byte_w[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (byte_w[7:1] == I2C_ADDR && !byte_w[0]) begin
                state_d         = ST_ADDR_ACK;
                busy_d          = 1'b1;
                first_pending_d = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // sda_oe doubles as the ACK phase marker: first SCL fall drives, second releases.
        ST_ADDR_ACK, ST_DATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_w[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (!rx_valid_q || rx_ready_i) begin
                rx_data_d       = byte_w;
                rx_valid_d      = 1'b1;
                rx_first_d      = first_pending_q;
                first_pending_d = 1'b0;
                state_d         = ST_DATA_ACK;
              end else begin
                overrun_d = 1'b1;
                state_d   = ST_IGNORE;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i2c_wb_clk_i) begin
    if (i2c_wb_rst_i) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= 3'd0;
      shift_q         <= 7'd0;
      sda_oe_q        <= 1'b0;
      rx_data_q       <= 8'h00;
      rx_valid_q      <= 1'b0;
      rx_first_q      <= 1'b0;
      first_pending_q <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      shift_q         <= shift_d;
      sda_oe_q        <= sda_oe_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      rx_first_q      <= rx_first_d;
      first_pending_q <= first_pending_d;
      busy_q          <= busy_d;
      overrun_q       <= overrun_d;
    end
  end

  assign sda_oe_o   = sda_oe_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_first_o = rx_first_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: behavioural I2C master, directed vector table,
// hand-written corner sequences and randomized transactions against a simple model.
module tb_i2c_target_rx;
  import i2c_spi_pkg::*;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b0;
  logic       sda_pad;
  logic       sda_oe, rx_valid, rx_first, busy, overrun;
  logic [7:0] rx_data;

  // Open-drain bus: either side pulling low wins.
  assign sda_pad = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_rx dut (
    .i2c_wb_clk_i(clk),
    .i2c_wb_rst_i(rst),
    .scl_i       (scl_m),
    .sda_i       (sda_pad),
    .sda_oe_o    (sda_oe),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (rx_ready),
    .rx_first_o  (rx_first),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  typedef struct {
    logic [6:0]      addr;
    logic            rw;
    int              nbytes;
    logic [2:0][7:0] data;
    logic            ready;
    logic            exp_addr_ack;
    logic [2:0]      exp_ack;
    logic            exp_overrun;
    logic            exp_ignore;
  } vec_t;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [8:0] cap_q[$];
  logic [8:0] exp_q[$];
  logic       model_overrun;

  always @(posedge clk) begin
    if (!rst && rx_valid && rx_ready) cap_q.push_back({rx_first, rx_data});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(2 * Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = ~sda_pad;
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic drain_and_compare(input string tag);
    rx_ready = 1'b1; tick(4);
    rx_ready = 1'b0; tick(1);
    checkOutput({tag, " byte count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      checkOutput($sformatf("%s byte %0d {first,data}", tag, i), cap_q[i], exp_q[i]);
    cap_q.delete();
    exp_q.delete();
  endtask

  task automatic applyStimulus(input vec_t v, output logic addr_ack, output logic [2:0] acks,
                               output logic busy_mid, output logic in_ignore);
    logic a;
    rx_ready = v.ready;
    acks = 3'b000;
    i2c_start();
    write_byte({v.addr, v.rw}, addr_ack);
    busy_mid = busy;
    for (int i = 0; i < v.nbytes; i++) begin
      write_byte(v.data[i], a);
      acks[i] = a;
    end
    in_ignore = (dut.state_q == ST_IGNORE);
    i2c_stop();
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    logic       addr_ack, busy_mid, in_ignore;
    logic [2:0] acks;
    applyStimulus(v, addr_ack, acks, busy_mid, in_ignore);
    checkOutput({tag, " addr ack"}, addr_ack, v.exp_addr_ack);
    for (int i = 0; i < v.nbytes; i++)
      checkOutput($sformatf("%s data ack %0d", tag, i), acks[i], v.exp_ack[i]);
    checkOutput({tag, " busy mid"}, busy_mid, v.exp_addr_ack);
    checkOutput({tag, " ignore state"}, in_ignore, v.exp_ignore);
    checkOutput({tag, " busy after stop"}, busy, 1'b0);
    checkOutput({tag, " overrun"}, overrun, v.exp_overrun);
    if (v.exp_addr_ack && v.nbytes > 0) begin
      if (v.ready) begin
        for (int i = 0; i < v.nbytes; i++) exp_q.push_back({(i == 0), v.data[i]});
      end else begin
        checkOutput({tag, " held valid"}, rx_valid, 1'b1);
        checkOutput({tag, " held data"}, rx_data, v.data[0]);
        checkOutput({tag, " held first"}, rx_first, 1'b1);
        exp_q.push_back({1'b1, v.data[0]});
      end
    end
    drain_and_compare(tag);
  endtask

  function automatic vec_t mk(input logic [6:0] a, input logic rw, input int n, input logic [23:0] d,
                              input logic rdy, input logic eaa, input logic [2:0] eack,
                              input logic eovr, input logic eign);
    vec_t v;
    v.addr = a; v.rw = rw; v.nbytes = n; v.data = d; v.ready = rdy;
    v.exp_addr_ack = eaa; v.exp_ack = eack; v.exp_overrun = eovr; v.exp_ignore = eign;
    return v;
  endfunction

  vec_t vecs[4];

  initial begin
    logic a;
    logic [6:0] ra;
    logic rrw, rrdy, addressed;
    int rn;
    vec_t v;

    vecs[0] = mk(7'h42, 1'b0, 1, 24'h0000A5, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0);
    vecs[1] = mk(7'h43, 1'b0, 1, 24'h000011, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    vecs[2] = mk(7'h42, 1'b1, 0, 24'h000000, 1'b1, 1'b0, 3'b000, 1'b0, 1'b1);
    vecs[3] = mk(7'h42, 1'b0, 2, 24'h000201, 1'b0, 1'b1, 3'b001, 1'b1, 1'b1);

    tick(3);
    rst = 1'b0;
    tick(1);
    checkOutput("reset sda_oe", sda_oe, 1'b0);
    checkOutput("reset rx_valid", rx_valid, 1'b0);
    checkOutput("reset rx_first", rx_first, 1'b0);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset overrun", overrun, 1'b0);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset state", dut.state_q, ST_IDLE);

    for (int i = 0; i < 4; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Repeated START mid-transaction: the second address ACK re-arms rx_first.
    rx_ready = 1'b1;
    i2c_start();
    write_byte(8'h84, a); checkOutput("rs addr1 ack", a, 1'b1);
    write_byte(8'h55, a); checkOutput("rs byte 55 ack", a, 1'b1);
    i2c_start();
    write_byte(8'h84, a); checkOutput("rs addr2 ack", a, 1'b1);
    write_byte(8'h66, a); checkOutput("rs byte 66 ack", a, 1'b1);
    i2c_stop();
    exp_q.push_back({1'b1, 8'h55});
    exp_q.push_back({1'b1, 8'h66});
    drain_and_compare("rs");

    // Reset while the target holds SDA low for the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) write_bit(i == 0 ? 1'b0 : ((8'h84 >> i) & 8'h01) != 0);
    sda_m = 1'b1;
    for (int k = 0; k < 20 && !sda_oe; k++) tick(1);
    checkOutput("rst-ack sda driven", sda_oe, 1'b1);
    rst = 1'b1; tick(1);
    rst = 1'b0;
    checkOutput("rst-ack sda released", sda_oe, 1'b0);
    checkOutput("rst-ack rx_valid", rx_valid, 1'b0);
    checkOutput("rst-ack state", dut.state_q, ST_IDLE);
    checkOutput("rst-ack overrun cleared", overrun, 1'b0);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
    rx_ready = 1'b1;
    write_byte(8'h77, a);
    checkOutput("rst-ack no-start byte nack", a, 1'b0);
    i2c_stop();
    drain_and_compare("rst-ack");

    model_overrun = 1'b0;
    for (int t = 0; t < 20; t++) begin
      ra   = ($urandom_range(0, 1) == 1) ? 7'h42 : 7'($urandom_range(0, 127));
      rrw  = ($urandom_range(0, 4) == 0);
      rn   = $urandom_range(1, 3);
      rrdy = 1'($urandom_range(0, 1));
      addressed = (ra == 7'h42) && !rrw;
      v.addr = ra; v.rw = rrw; v.nbytes = rn; v.ready = rrdy;
      v.data = 24'($urandom);
      v.exp_addr_ack = addressed;
      v.exp_ack = 3'b000;
      for (int i = 0; i < rn; i++) v.exp_ack[i] = addressed && (rrdy || i == 0);
      if (addressed && !rrdy && rn >= 2) model_overrun = 1'b1;
      v.exp_overrun = model_overrun;
      v.exp_ignore = !addressed || (!rrdy && rn >= 2);
      run_vec($sformatf("rand%0d", t), v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx.md
I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h42, the 7-bit target address this block responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the flip-flop depth of the SCL/SDA input synchronisers.
REQ-003 SHALL have port i2c_wb_clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port i2c_wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port scl_i  input  1  raw I2C clock pad level.
REQ-006 SHALL have port sda_i  input  1  raw I2C data pad level.
REQ-007 SHALL have port sda_oe_o  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 SHALL have port rx_data_o  output  8  received data byte toward the SPI stage.
REQ-009 SHALL have port rx_valid_o  output  1  rx_data_o holds an unconsumed byte.
REQ-010 SHALL have port rx_ready_i  input  1  SPI stage accepts the byte this cycle.
REQ-011 SHALL have port rx_first_o  output  1  held byte is the first data byte after the address.
REQ-012 SHALL have port busy_o  output  1  addressed transaction in progress (ADDR_ACK through STOP).
REQ-013 SHALL have port overrun_o  output  1  sticky flag: byte NACKed because the holding register was full.

Function
REQ-014 SHALL pass scl_i/sda_i through SYNC_STAGES flip-flops, then one history flop, for edge detection; edges are seen SYNC_STAGES+1 cycles after the pad change.
REQ-015 SHALL detect START as synchronised SDA 1->0 while SCL=1, and STOP as SDA 0->1 while SCL=1.
REQ-016 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-017 SHALL move to ADDR on START from any state (repeated START included), clearing the bit counter.
REQ-018 SHALL move to IDLE on STOP from any state and release sda_oe_o in the same cycle.
REQ-019 SHALL sample SDA MSB-first on each SCL rising edge in ADDR/DATA, with a 3-bit counter wrapping 7->0 at byte end.
REQ-020 SHALL, after the 8th address bit, go to ADDR_ACK if the address equals I2C_ADDR and R/W=0; otherwise go to IGNORE, keeping SDA released (NACK).
REQ-021 SHALL, in ADDR_ACK and DATA_ACK when ACKing, assert sda_oe_o on the next SCL falling edge and deassert it on the following SCL falling edge, then enter DATA.
REQ-022 SHALL, at the 8th data bit, load the byte into the holding register only if rx_valid_o=0 or rx_ready_i=1 in that cycle; rx_valid_o rises the following cycle and the byte is ACKed.
REQ-023 SHALL, if the holding register is full at the 8th data bit, discard the byte, NACK it, set overrun_o, and enter IGNORE.
REQ-024 SHALL clear rx_valid_o the cycle after rx_valid_o=1 and rx_ready_i=1, unless a new byte loads in that same cycle.
REQ-025 SHALL keep rx_data_o and rx_first_o stable while rx_valid_o=1 and rx_ready_i=0.
REQ-026 SHALL set rx_first_o with the first byte loaded after each address ACK, and clear it for subsequent bytes.
REQ-027 SHALL stay in IGNORE, releasing SDA, until START or STOP.
REQ-028 SHALL operate correctly when i2c_wb_clk_i >= 16x the SCL frequency; slower clocks are unsupported.

Reset
REQ-029 SHALL, with i2c_wb_rst_i=1 at a clock edge, enter IDLE and set sda_oe_o=0, rx_valid_o=0, rx_first_o=0, busy_o=0, overrun_o=0, rx_data_o=8'h00, and the synchroniser flops to 1 (idle bus).
REQ-030 SHALL, on reset mid-transfer, drop any held byte and release SDA; a START is required before the next byte is accepted.
REQ-031 SHALL clear overrun_o only by reset.

Structure
REQ-032 SHALL take the state enum and the default I2C_ADDR constant from the shared package i2c_spi_pkg.
REQ-033 SHALL instantiate one sub-module, i2c_sync_edge, holding the synchroniser and rise/fall detection for a single line; it is instantiated once for SCL and once for SDA.

Verification
REQ-034 SHALL cover: START, address 0x42 with W, data 0xA5, STOP, rx_ready_i=1 -> ACK on both bytes, one rx_valid_o pulse, rx_data_o=0xA5, rx_first_o=1.
REQ-035 SHALL cover: address 0x43 with W, then data 0x11 -> NACK on the address, no rx_valid_o, state IGNORE until STOP.
REQ-036 SHALL cover: address 0x42 with R -> NACK, busy_o remains 0.
REQ-037 SHALL cover: bytes 0x01 then 0x02 with rx_ready_i=0 -> 0x01 held and ACKed, 0x02 NACKed, overrun_o=1, rx_data_o stays 0x01.
REQ-038 SHALL cover: repeated START after byte 0x55, then address 0x42, byte 0x66 -> next held byte 0x66 with rx_first_o=1.
REQ-039 SHALL cover: i2c_wb_rst_i pulsed during the ACK low phase -> sda_oe_o=0 the next cycle, rx_valid_o=0, state IDLE.
